// File: rtl/display_timing_gen_if.sv
// Raster timing bundle: pixel enable in, coordinates/syncs/strobes out.
// DISPLAY_TIMING_FRAME_CNT_EN adds the frame_count output.
interface display_timing_gen_if;
  logic       pix_en;
  logic [9:0] x;
  logic [9:0] y;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       line_start;
  logic       frame_start;
`ifdef DISPLAY_TIMING_FRAME_CNT_EN
  logic [15:0] frame_count;
`endif

  modport master (
    input  pix_en,
    output x, y, hsync, vsync,
    output video_on, line_start, frame_start
`ifdef DISPLAY_TIMING_FRAME_CNT_EN
    , output frame_count
`endif
  );

  modport slave (
    output pix_en,
    input  x, y, hsync, vsync,
    input  video_on, line_start, frame_start
`ifdef DISPLAY_TIMING_FRAME_CNT_EN
    , input frame_count
`endif
  );
endinterface

// File: rtl/display_timing_gen.sv
// Raster timing generator: x/y counters, syncs, blanking and frame strobes.
// DISPLAY_TIMING_FRAME_CNT_EN enables a 16-bit frame counter output.
module display_timing_gen #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic p_clock,
  input  logic reset,
  display_timing_gen_if.master bus
);

  localparam int HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST = 11'(HT - 1);
  localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
  localparam logic [10:0] H_SB   = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_SE   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_LAST = 11'(VT - 1);
  localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
  localparam logic [10:0] V_SB   = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] V_SE   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  state_t      state_n;
  logic [9:0]  x_n;
  logic [9:0]  y_n;
  logic [10:0] xc;
  logic [10:0] yc;
  logic [10:0] xn_w;
  logic [10:0] yn_w;
  logic        x_wrap;
  logic        y_wrap;
  logic        hs_n;
  logic        vs_n;
  logic        vo_n;

  assign xc     = {1'b0, bus.x};
  assign yc     = {1'b0, bus.y};
  assign x_wrap = (xc == H_LAST);
  assign y_wrap = (yc == V_LAST);

  always_ff @(posedge p_clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    x_n     = bus.x;
    y_n     = bus.y;
    if (bus.pix_en) begin
      unique case (state)
        IDLE: begin
          x_n     = '0;
          y_n     = '0;
          state_n = RUN;
        end
        RUN: begin
          x_n = x_wrap ? '0 : bus.x + 10'd1;
          if (x_wrap)
            y_n = y_wrap ? '0 : bus.y + 10'd1;
        end
      endcase
    end
  end

  // Flags derive from the next coordinates so every output names one pixel
  assign xn_w = {1'b0, x_n};
  assign yn_w = {1'b0, y_n};
  assign hs_n = (xn_w >= H_SB && xn_w < H_SE) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vs_n = (yn_w >= V_SB && yn_w < V_SE) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vo_n = (xn_w < H_VIS) && (yn_w < V_VIS);

  always_ff @(posedge p_clock or posedge reset) begin
    if (reset) begin
      bus.x           <= '0;
      bus.y           <= '0;
      bus.hsync       <= ~SYNC_ACTIVE;
      bus.vsync       <= ~SYNC_ACTIVE;
      bus.video_on    <= 1'b0;
      bus.line_start  <= 1'b0;
      bus.frame_start <= 1'b0;
    end else if (bus.pix_en) begin
      bus.x           <= x_n;
      bus.y           <= y_n;
      bus.hsync       <= hs_n;
      bus.vsync       <= vs_n;
      bus.video_on    <= vo_n;
      bus.line_start  <= (x_n == '0);
      bus.frame_start <= (x_n == '0) && (y_n == '0);
    end else begin
      bus.line_start  <= 1'b0;
      bus.frame_start <= 1'b0;
    end
  end

`ifdef DISPLAY_TIMING_FRAME_CNT_EN
  logic fc_inc;
  assign fc_inc = bus.pix_en && (state == RUN) && x_wrap && y_wrap;

  always_ff @(posedge p_clock or posedge reset) begin
    if (reset)       bus.frame_count <= '0;
    else if (fc_inc) bus.frame_count <= bus.frame_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_display_timing_gen.sv
// Bench for display_timing_gen: default 640x480 timing plus a tiny raster.
// Outputs are compared each cycle against an index-based raster model.
module tb_display_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pe_a = 1'b0;
  logic pe_b = 1'b0;
  int   total = 0;
  int   pass = 0;

  always #5 clk = ~clk;

  display_timing_gen_if ifa ();
  display_timing_gen_if ifb ();
  assign ifa.pix_en = pe_a;
  assign ifb.pix_en = pe_b;

  display_timing_gen u_a (
    .p_clock (clk),
    .reset   (rst),
    .bus     (ifa)
  );

  display_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SYNC_ACTIVE(1'b1)
  ) u_b (
    .p_clock (clk),
    .reset   (rst),
    .bus     (ifb)
  );

  typedef struct {
    int x; int y;
    int hs; int vs; int vo; int ls; int fs; int fc;
  } exp_t;

  // n = enabled pixels since the frame-start load; the raster is a pure
  // function of n: x = n mod H_TOTAL, y = (n div H_TOTAL) mod V_TOTAL.
  function automatic exp_t model(
    input int n, input bit st, input bit en,
    input int hv, input int hf, input int hsw, input int hb,
    input int vv, input int vf, input int vsw, input int vb,
    input bit sa);
    exp_t e;
    int ht, vt;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    if (!st) begin
      e.x = 0; e.y = 0; e.hs = int'(!sa); e.vs = int'(!sa);
      e.vo = 0; e.ls = 0; e.fs = 0; e.fc = 0;
    end else begin
      e.x = n % ht;
      e.y = (n / ht) % vt;
      e.hs = (e.x >= hv + hf && e.x < hv + hf + hsw) ? int'(sa) : int'(!sa);
      e.vs = (e.y >= vv + vf && e.y < vv + vf + vsw) ? int'(sa) : int'(!sa);
      e.vo = (e.x < hv && e.y < vv) ? 1 : 0;
      e.ls = (en && e.x == 0) ? 1 : 0;
      e.fs = (e.ls == 1 && e.y == 0) ? 1 : 0;
      e.fc = (n / (ht * vt)) % 65536;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act == expv) pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
  endtask

  task automatic chk_out(input string p, input exp_t e,
    input int x, input int y, input int hs, input int vs,
    input int vo, input int ls, input int fs);
    chk({p, ".x"}, x, e.x);
    chk({p, ".y"}, y, e.y);
    chk({p, ".hsync"}, hs, e.hs);
    chk({p, ".vsync"}, vs, e.vs);
    chk({p, ".video_on"}, vo, e.vo);
    chk({p, ".line_start"}, ls, e.ls);
    chk({p, ".frame_start"}, fs, e.fs);
  endtask

  int na = 0;
  bit sta = 1'b0;
  bit ena = 1'b0;
  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      na = 0; sta = 1'b0; ena = 1'b0;
    end else begin
      ena = pe_a;
      if (pe_a) begin
        if (sta) na++;
        else sta = 1'b1;
      end
    end
    e = model(na, sta, ena, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
    #1;
    chk_out("a", e, int'(ifa.x), int'(ifa.y), int'(ifa.hsync),
      int'(ifa.vsync), int'(ifa.video_on), int'(ifa.line_start),
      int'(ifa.frame_start));
`ifdef DISPLAY_TIMING_FRAME_CNT_EN
    chk("a.frame_count", int'(ifa.frame_count), e.fc);
`endif
  end

  int nb = 0;
  bit stb = 1'b0;
  bit enb = 1'b0;
  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      nb = 0; stb = 1'b0; enb = 1'b0;
    end else begin
      enb = pe_b;
      if (pe_b) begin
        if (stb) nb++;
        else stb = 1'b1;
      end
    end
    e = model(nb, stb, enb, 8, 2, 3, 2, 6, 1, 2, 1, 1'b1);
    #1;
    chk_out("b", e, int'(ifb.x), int'(ifb.y), int'(ifb.hsync),
      int'(ifb.vsync), int'(ifb.video_on), int'(ifb.line_start),
      int'(ifb.frame_start));
`ifdef DISPLAY_TIMING_FRAME_CNT_EN
    chk("b.frame_count", int'(ifb.frame_count), e.fc);
`endif
  end

  initial begin
    int hs_low, vo_cnt, vs_hi;
    int ls1, ls2, fs1, fs2;
    int found;

    repeat (3) @(negedge clk);
    chk("rst.a.hsync", int'(ifa.hsync), 1);
    chk("rst.b.hsync", int'(ifb.hsync), 0);
    chk("rst.a.video_on", int'(ifa.video_on), 0);

    // Continuous enable: line 0 of default raster, several tiny frames
    rst = 1'b0; pe_a = 1'b1; pe_b = 1'b1;
    hs_low = 0; vo_cnt = 0; vs_hi = 0;
    ls1 = -1; ls2 = -1; fs1 = -1; fs2 = -1;
    for (int k = 0; k < 1600; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("first.x", int'(ifa.x), 0);
        chk("first.y", int'(ifa.y), 0);
        chk("first.video_on", int'(ifa.video_on), 1);
        chk("first.frame_start", int'(ifa.frame_start), 1);
        chk("first.b.frame_start", int'(ifb.frame_start), 1);
      end
      if (k < 800 && ifa.hsync == 1'b0) hs_low++;
      if (k < 800 && ifa.video_on) vo_cnt++;
      if (k < 150 && ifb.vsync == 1'b1) vs_hi++;
      if (ifa.line_start) begin
        if (ls1 < 0) ls1 = k;
        else if (ls2 < 0) ls2 = k;
      end
      if (ifb.frame_start) begin
        if (fs1 < 0) fs1 = k;
        else if (fs2 < 0) fs2 = k;
      end
    end
    chk("line0.hsync_low_cycles", hs_low, 96);
    chk("line0.video_on_cycles", vo_cnt, 640);
    chk("line_start.gap", ls2 - ls1, 800);
    chk("b.vsync_active_cycles", vs_hi, 30);
    chk("b.frame_gap", fs2 - fs1, 150);

    // Enable on one cycle in four: tiny frame stretches to 600 cycles
    fs1 = -1; fs2 = -1;
    for (int k = 0; k < 1500; k++) begin
      pe_a = (k % 4 == 0);
      pe_b = (k % 4 == 0);
      @(negedge clk);
      if (ifb.frame_start) begin
        if (fs1 < 0) fs1 = k;
        else if (fs2 < 0) fs2 = k;
      end
    end
    chk("b.frame_gap_quarter", fs2 - fs1, 600);

    for (int k = 0; k < 3000; k++) begin
      pe_a = 1'($urandom_range(0, 1));
      pe_b = ($urandom % 3) != 0;
      @(negedge clk);
    end

    // Reset mid-frame at a chosen tiny-raster position
    pe_a = 1'b1; pe_b = 1'b1;
    found = 0;
    for (int k = 0; k < 300 && found == 0; k++) begin
      @(negedge clk);
      if (ifb.x == 10'd5 && ifb.y == 10'd3) found = 1;
    end
    chk("midreset.position_found", found, 1);
    rst = 1'b1;
    #1;
    chk("midreset.b.x", int'(ifb.x), 0);
    chk("midreset.b.y", int'(ifb.y), 0);
    chk("midreset.b.hsync", int'(ifb.hsync), 0);
    chk("midreset.a.video_on", int'(ifa.video_on), 0);
    chk("midreset.a.x", int'(ifa.x), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("after_reset.b.frame_start", int'(ifb.frame_start), 1);
    chk("after_reset.b.x", int'(ifb.x), 0);
    chk("after_reset.a.frame_start", int'(ifa.frame_start), 1);

    for (int k = 0; k < 400; k++) begin
      pe_a = ($urandom % 4) != 0;
      pe_b = 1'($urandom_range(0, 1));
      @(negedge clk);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
